filter_loader: RTL and testbench
================================

FILTER_LOADER -- requirements
Module: filter_loader

Interface
REQ-001 The block SHALL take parameter HEIGHT, default 16, as the filter buffer depth in words.
REQ-002 The block SHALL take parameter FILTER_SIZE, default 8, as the number of words per filter.
REQ-003 The block SHALL take parameter DATA_WIDTH, default 16, as the coefficient word width.
REQ-004 The block SHALL expose port clk, input, 1 bit, as the single clock (rising edge).
REQ-005 The block SHALL expose port rst, input, 1 bit, as the reset; it is asynchronous and active-low.
REQ-006 The block SHALL expose port start, input, 1 bit, as a pulse that begins a load job.
REQ-007 The block SHALL expose port num_filters, input, 8 bits, as the filter count for the job, sampled on start.
REQ-008 The block SHALL expose port in_data, input, DATA_WIDTH bits, as the coefficient stream data.
REQ-009 The block SHALL expose port in_valid, input, 1 bit, as the stream valid.
REQ-010 The block SHALL expose port in_ready, output, 1 bit, as the stream ready.
REQ-011 The block SHALL expose port filter_consumed, input, 1 bit, as a pulse from the reader that frees the oldest filter slot.
REQ-012 The block SHALL expose buffer write ports: Waddr, output, AW=clog2(HEIGHT) bits; Wdata, output, DATA_WIDTH bits; Wen, output, 1 bit.
REQ-013 The block SHALL expose port filter_head, output, AW bits, as the base address of the oldest valid filter.
REQ-014 The block SHALL expose port filter_rdy, output, 1 bit, meaning at least one complete filter is buffered.
REQ-015 The block SHALL expose port full, output, 1 bit, meaning all slots are occupied.
REQ-016 The block SHALL expose port done, output, 1 bit, as a one-cycle pulse when the job completes.

Function
REQ-017 The block SHALL define NUM_SLOTS = HEIGHT/FILTER_SIZE and fail elaboration unless HEIGHT is a nonzero multiple of FILTER_SIZE.
REQ-018 The FSM SHALL have exactly two states: IDLE and LOAD; in IDLE, start moves to LOAD and loads a remaining-filter counter from num_filters.
REQ-019 In IDLE, start with num_filters==0 SHALL pulse done on the next cycle, stay in IDLE and perform no writes.
REQ-020 The block SHALL drive in_ready = (state==LOAD) && !full, combinationally.
REQ-021 On handshake (in_valid && in_ready), the next cycle SHALL show Wen=1, Wdata=in_data and Waddr=(write_head+index) mod HEIGHT (one-cycle registered latency); otherwise Wen=0.
REQ-022 The index counter SHALL increment per handshake in 0..FILTER_SIZE-1; on the last word it SHALL wrap to 0, advance write_head by FILTER_SIZE mod HEIGHT, increment occupancy and decrement the remaining count.
REQ-023 When the remaining count reaches 0, the block SHALL pulse done in the same cycle as the final Wen and return to IDLE.
REQ-024 filter_consumed with occupancy>0 SHALL decrement occupancy and advance filter_head by FILTER_SIZE mod HEIGHT; with occupancy==0 it SHALL be ignored.
REQ-025 A filter completion and filter_consumed in the same cycle SHALL leave occupancy unchanged and advance both heads.
REQ-026 full SHALL equal (occupancy==NUM_SLOTS) and filter_rdy SHALL equal (occupancy!=0); both SHALL be registered.
REQ-027 start while in LOAD SHALL be ignored, and in_valid while in IDLE SHALL not be accepted.
REQ-028 Occupancy SHALL have clog2(NUM_SLOTS+1) bits, and head arithmetic SHALL wrap modulo HEIGHT.

Reset
REQ-029 Asserting rst low SHALL, at any time, force IDLE; clear index, write_head, filter_head, occupancy and the remaining count; and drive in_ready=0, Wen=0, Waddr=0, Wdata=0, filter_head=0, filter_rdy=0, full=0 and done=0.
REQ-030 A partially written filter SHALL be discarded on reset, and deassertion SHALL require a fresh start.

Structure
REQ-031 Package filter_pkg SHALL hold the state enum (IDLE, LOAD) and the clog2-based width helper shared with the filter read-side address generator.
REQ-032 The index counter and head registers SHALL use one sub-module, mod_counter (parameterised modulus and step, with clr and inc), instantiated three times: index, write_head, filter_head.

Verification
REQ-033 Reset, then start with num_filters=2 and stream 16 words 0..15 with valid held -> Waddr 0..15, Wdata 0..15; full=1 after word 15; done pulses with the last Wen.
REQ-034 Start with num_filters=3 and no consumes -> in_ready=0 after 16 words; one filter_consumed -> filter_head=8, in_ready=1, and words 16..23 are written to Waddr 0..7.
REQ-035 Filter completion coincident with filter_consumed at occupancy 1 -> occupancy stays 1, filter_rdy=1 and full=0.
REQ-036 Pulse filter_consumed at occupancy 0 -> no change, filter_head=0.
REQ-037 Drive rst low after 5 words -> all outputs return to zero immediately; a new job with num_filters=1 writes starting at Waddr 0.
REQ-038 Start with num_filters=0 -> done pulses next cycle and Wen is never asserted.

Source files
------------

// File: rtl/filter_pkg.sv
// filter_pkg: state encoding and width helper shared by filter load/read address logic
package filter_pkg;
    typedef enum logic {IDLE, LOAD} state_t;
    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mod_counter.sv
// mod_counter: wrapping counter q += STEP mod MOD on inc, cleared by clr; ports clk, rst (async low), clr, inc, q
module mod_counter
    import filter_pkg::*;
#(
    parameter int MOD  = 8,
    parameter int STEP = 1,
    parameter int W    = clog2w(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    localparam logic [W:0] M = (W+1)'(MOD);
    localparam logic [W:0] S = (W+1)'(STEP % MOD);
    logic [W:0] sum;
    assign sum = {1'b0, q} + S;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc)
            q <= (sum >= M) ? W'(sum - M) : W'(sum);
    end
endmodule

// File: rtl/filter_loader.sv
// filter_loader: streams filter coefficients into a ring of slots; ports clk, rst, start/num_filters (job), in_* (stream), filter_consumed, W* (buffer write), filter_head/filter_rdy/full/done (status)
module filter_loader
    import filter_pkg::*;
#(
    parameter int HEIGHT      = 16,
    parameter int FILTER_SIZE = 8,
    parameter int DATA_WIDTH  = 16,
    localparam int AW         = clog2w(HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            num_filters,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  filter_consumed,
    output logic [AW-1:0]         Waddr,
    output logic [DATA_WIDTH-1:0] Wdata,
    output logic                  Wen,
    output logic [AW-1:0]         filter_head,
    output logic                  filter_rdy,
    output logic                  full,
    output logic                  done
);
    localparam int NUM_SLOTS = HEIGHT / FILTER_SIZE;
    localparam int IW        = clog2w(FILTER_SIZE);
    localparam int OW        = clog2w(NUM_SLOTS + 1);

    if (FILTER_SIZE == 0 || HEIGHT == 0 || HEIGHT % FILTER_SIZE != 0) begin : g_bad_geometry
        $error("HEIGHT must be a nonzero multiple of FILTER_SIZE");
    end

    state_t          state, state_nx;
    logic [IW-1:0]   index;
    logic [AW-1:0]   write_head;
    logic [OW-1:0]   occ, occ_nx;
    logic [7:0]      remaining;
    logic            hs, last, cons, job_end, job_start, empty_job;
    logic [AW:0]     addr_sum;

    always_comb begin
        in_ready  = (state == LOAD) && !full;
        hs        = in_valid && in_ready;
        last      = hs && (index == IW'(FILTER_SIZE - 1));
        job_end   = last && (remaining == 8'd1);
        job_start = (state == IDLE) && start;
        empty_job = job_start && (num_filters == 8'd0);
        cons      = filter_consumed && (occ != '0);
        state_nx  = job_end ? IDLE : (job_start && !empty_job) ? LOAD : state;
        occ_nx    = (last && !cons) ? occ + OW'(1) : (cons && !last) ? occ - OW'(1) : occ;
        addr_sum  = {1'b0, write_head} + (AW+1)'(index);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ        <= '0;
            remaining  <= '0;
            Wen        <= 1'b0;
            Waddr      <= '0;
            Wdata      <= '0;
            filter_rdy <= 1'b0;
            full       <= 1'b0;
            done       <= 1'b0;
        end else begin
            occ        <= occ_nx;
            filter_rdy <= occ_nx != '0;
            full       <= occ_nx == OW'(NUM_SLOTS);
            Wen        <= hs;
            done       <= job_end || empty_job;
            if (job_start)
                remaining <= num_filters;
            else if (last)
                remaining <= remaining - 8'd1;
            if (hs) begin
                Waddr <= (addr_sum >= (AW+1)'(HEIGHT)) ? AW'(addr_sum - (AW+1)'(HEIGHT)) : AW'(addr_sum);
                Wdata <= in_data;
            end
        end
    end

    mod_counter #(.MOD(FILTER_SIZE), .STEP(1), .W(IW)) u_index (
        .clk(clk), .rst(rst), .clr(job_start), .inc(hs), .q(index)
    );

    mod_counter #(.MOD(HEIGHT), .STEP(FILTER_SIZE), .W(AW)) u_write_head (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(last), .q(write_head)
    );

    mod_counter #(.MOD(HEIGHT), .STEP(FILTER_SIZE), .W(AW)) u_filter_head (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(cons), .q(filter_head)
    );
endmodule

// File: tb/tb_filter_loader.sv
// tb_filter_loader: directed table and sequence checks for filter_loader
module tb_filter_loader;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    num_filters = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          filter_consumed = 1'b0;
    logic          in_ready, Wen, filter_rdy, full, done;
    logic [AW-1:0] Waddr, filter_head;
    logic [DW-1:0] Wdata;

    filter_loader dut (
        .clk(clk), .rst(rst), .start(start), .num_filters(num_filters),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .filter_consumed(filter_consumed), .Waddr(Waddr), .Wdata(Wdata), .Wen(Wen),
        .filter_head(filter_head), .filter_rdy(filter_rdy), .full(full), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [7:0]  nf;
        logic        v;
        logic [15:0] d;
        logic        c;
        logic        wen;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        ir;
        logic [3:0]  fh;
        logic        fr;
        logic        fu;
        logic        dn;
    } vec_t;

    vec_t tbl[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic st, input logic [7:0] nf, input logic v, input logic [15:0] d,
                                input logic c, input logic wen, input logic [3:0] wa, input logic [15:0] wd,
                                input logic ir, input logic [3:0] fh, input logic fr, input logic fu, input logic dn);
        tbl.push_back('{st, nf, v, d, c, wen, wa, wd, ir, fh, fr, fu, dn});
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, " wen"}, Wen, 0);
        chk({tag, " waddr"}, Waddr, 0);
        chk({tag, " wdata"}, Wdata, 0);
        chk({tag, " in_ready"}, in_ready, 0);
        chk({tag, " filter_head"}, filter_head, 0);
        chk({tag, " filter_rdy"}, filter_rdy, 0);
        chk({tag, " full"}, full, 0);
        chk({tag, " done"}, done, 0);
    endtask

    initial begin
        // two-filter job fills both slots, then drain, idle-side corner cases
        add(1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++)
            add(0, 0, 1, 16'(k), 0, 1, 4'(k), 16'(k), k != 15, 0, k >= 7, k == 15, k == 15);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 8, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 16'h00aa, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        tick();
        tick();
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        tick();

        foreach (tbl[i]) begin
            start = tbl[i].st;
            num_filters = tbl[i].nf;
            in_valid = tbl[i].v;
            in_data = tbl[i].d;
            filter_consumed = tbl[i].c;
            tick();
            chk($sformatf("v%0d wen", i), Wen, tbl[i].wen);
            chk($sformatf("v%0d in_ready", i), in_ready, tbl[i].ir);
            chk($sformatf("v%0d filter_head", i), filter_head, tbl[i].fh);
            chk($sformatf("v%0d filter_rdy", i), filter_rdy, tbl[i].fr);
            chk($sformatf("v%0d full", i), full, tbl[i].fu);
            chk($sformatf("v%0d done", i), done, tbl[i].dn);
            if (tbl[i].wen) begin
                chk($sformatf("v%0d waddr", i), Waddr, tbl[i].wa);
                chk($sformatf("v%0d wdata", i), Wdata, tbl[i].wd);
            end
        end
        start = 0;
        in_valid = 0;
        filter_consumed = 0;

        // three filters into two slots: stall when full, resume after a consume
        start = 1;
        num_filters = 3;
        tick();
        start = 0;
        in_valid = 1;
        for (int k = 0; k < 16; k++) begin
            in_data = 16'(k);
            tick();
            chk($sformatf("s3 waddr%0d", k), Waddr, k);
        end
        chk("s3 stall in_ready", in_ready, 0);
        chk("s3 stall full", full, 1);
        in_data = 16;
        tick();
        chk("s3 stall wen", Wen, 0);
        in_valid = 0;
        filter_consumed = 1;
        tick();
        chk("s3 consume head", filter_head, 8);
        chk("s3 consume full", full, 0);
        chk("s3 consume in_ready", in_ready, 1);
        in_valid = 1;
        for (int k = 0; k < 8; k++) begin
            in_data = 16'(16 + k);
            filter_consumed = (k == 7);
            tick();
            chk($sformatf("s3b wen%0d", k), Wen, 1);
            chk($sformatf("s3b waddr%0d", k), Waddr, k);
            chk($sformatf("s3b wdata%0d", k), Wdata, 16 + k);
            chk($sformatf("s3b done%0d", k), done, k == 7);
        end
        in_valid = 0;
        filter_consumed = 0;
        chk("coinc filter_rdy", filter_rdy, 1);
        chk("coinc full", full, 0);
        chk("coinc head", filter_head, 0);
        chk("coinc in_ready", in_ready, 0);
        tick();
        chk("coinc done clr", done, 0);
        chk("coinc rdy hold", filter_rdy, 1);

        // asynchronous reset in the middle of a filter
        start = 1;
        num_filters = 1;
        tick();
        start = 0;
        in_valid = 1;
        for (int k = 0; k < 5; k++) begin
            in_data = 16'(100 + k);
            tick();
        end
        chk("pre-rst waddr", Waddr, 12);
        chk("pre-rst wen", Wen, 1);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("async rst");
        in_valid = 0;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1;
        in_data = 16'h0bad;
        tick();
        chk("post-rst idle wen", Wen, 0);
        chk("post-rst idle in_ready", in_ready, 0);
        in_valid = 0;
        start = 1;
        num_filters = 1;
        tick();
        start = 0;
        in_valid = 1;
        for (int k = 0; k < 8; k++) begin
            in_data = 16'(200 + k);
            tick();
            chk($sformatf("new waddr%0d", k), Waddr, k);
            chk($sformatf("new wdata%0d", k), Wdata, 200 + k);
        end
        in_valid = 0;
        chk("new done", done, 1);
        chk("new filter_rdy", filter_rdy, 1);

        // empty job
        start = 1;
        num_filters = 0;
        tick();
        start = 0;
        chk("nf0 done", done, 1);
        chk("nf0 wen", Wen, 0);
        in_valid = 1;
        tick();
        chk("nf0 done clr", done, 0);
        chk("nf0 wen after", Wen, 0);
        chk("nf0 in_ready", in_ready, 0);
        in_valid = 0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
